// File: rtl/memory_controller.sv
// Word-addressed backing store behind the cache: serves one request at a time
// over a level-based four-phase handshake, with a fixed access latency.
module memory_controller #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [32:0] memory_request,
  input  logic        memory_request_ready,
  output logic [15:0] memory_response,
  output logic        memory_response_ready,
  output logic        busy,
  output logic [1:0]  state_debug
);

  // Handshake: the cache raises memory_request_ready with a stable request and
  // holds it until it sees memory_response_ready. The request is sampled once,
  // on the capture edge. memory_response_ready then stays high until the cache
  // drops its level, and falls on the following edge. If the cache drops its
  // level early, the access still completes and the response is a one-cycle pulse.

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                 state;
  logic [3:0]             count;
  logic                   req_write;
  logic [15:0]            req_data;
  logic [ADDR_BITS-1:0]   req_index;
  logic [15:0]            store [DEPTH];

  assign state_debug = state;

  generate
    if (ADDR_BITS < 16) begin : g_alias
      // Upper address bits alias onto the low ones and are never stored.
      logic unused_addr_bits;
      assign unused_addr_bits = ^memory_request[15:ADDR_BITS];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      count                 <= '0;
      req_write             <= 1'b0;
      req_data              <= '0;
      req_index             <= '0;
      memory_response       <= '0;
      memory_response_ready <= 1'b0;
      busy                  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (memory_request_ready) begin
            req_write <= memory_request[32];
            req_data  <= memory_request[31:16];
            req_index <= memory_request[ADDR_BITS-1:0];
            count     <= COUNT_LOAD;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          // A write commits here even if the cache has already abandoned the request.
          if (count == 4'd0) begin
            if (req_write) begin
              store[req_index] <= req_data;
              memory_response  <= req_data;
            end else begin
              memory_response  <= store[req_index];
            end
            memory_response_ready <= 1'b1;
            state                 <= RESPOND;
          end else begin
            count <= count - 4'd1;
          end
        end

        RESPOND: begin
          if (!memory_request_ready) begin
            memory_response_ready <= 1'b0;
            busy                  <= 1'b0;
            state                 <= IDLE;
          end
        end

        default: begin
          state                 <= IDLE;
          memory_response_ready <= 1'b0;
          busy                  <= 1'b0;
        end
      endcase
    end
  end

  a_ready_implies_busy: assert property (
    @(posedge clock) disable iff (!reset) memory_response_ready |-> busy
  );

  a_state_legal: assert property (
    @(posedge clock) disable iff (!reset) state != 2'd3
  );

endmodule

// File: tb/tb_memory_controller.sv
// Randomised scoreboard bench for memory_controller: a driver issues transactions
// against an array model, and a monitor checks data, latency and pulse width.
module tb_memory_controller;

  localparam int ADDR_BITS = 8;
  localparam int LATENCY   = 4;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic        clock;
  logic        reset;
  logic [32:0] memory_request;
  logic        memory_request_ready;
  logic [15:0] memory_response;
  logic        memory_response_ready;
  logic        busy;
  logic [1:0]  state_debug;

  int errors = 0;
  int checks = 0;

  logic [15:0] model_mem [DEPTH];
  logic [15:0] exp_q[$];
  int          len_q[$];

  memory_controller #(.ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .memory_request        (memory_request),
    .memory_request_ready  (memory_request_ready),
    .memory_response       (memory_response),
    .memory_response_ready (memory_response_ready),
    .busy                  (busy),
    .state_debug           (state_debug)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // monitor / scoreboard
  bit          prev_rdy  = 1'b0;
  bit          prev_busy = 1'b0;
  int          cyc       = 0;
  int          width     = 0;
  int          cur_len   = 0;
  logic [15:0] cur_exp   = '0;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        prev_rdy  = 1'b0;
        prev_busy = 1'b0;
        width     = 0;
      end else begin
        if (busy && !prev_busy) cyc = 0;
        else if (busy) cyc++;

        if (memory_response_ready && !prev_rdy) begin
          check("latency", cyc, LATENCY);
          check("busy_during_resp", {31'd0, busy}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_response: got 0x%0h with no expected entry", memory_response);
          end else begin
            cur_exp = exp_q.pop_front();
            cur_len = len_q.pop_front();
            check("resp_data", {16'd0, memory_response}, {16'd0, cur_exp});
          end
          width = 1;
        end else if (memory_response_ready) begin
          width++;
          check("resp_hold", {16'd0, memory_response}, {16'd0, cur_exp});
        end

        if (!memory_response_ready && prev_rdy) begin
          check("resp_width", width, cur_len);
          check("busy_clear", {31'd0, busy}, 32'd0);
          check("resp_retained", {16'd0, memory_response}, {16'd0, cur_exp});
        end

        prev_rdy  = memory_response_ready;
        prev_busy = busy;
      end
    end
  end

  // driver tasks
  task automatic run_txn(input bit wr, input logic [15:0] data, input logic [15:0] addr,
                         input int hold, input bit abort, input int abort_d,
                         input bit scramble, input logic [32:0] scramble_req);
    logic [15:0] e;
    int n;
    if (wr) begin
      model_mem[addr[ADDR_BITS-1:0]] = data;
      e = data;
    end else begin
      e = model_mem[addr[ADDR_BITS-1:0]];
    end
    exp_q.push_back(e);
    len_q.push_back(abort ? 1 : hold + 1);

    @(negedge clock);
    memory_request       = {wr, data, addr};
    memory_request_ready = 1'b1;
    @(negedge clock);
    if (scramble) memory_request = scramble_req;
    if (abort) begin
      repeat (abort_d) @(negedge clock);
      memory_request_ready = 1'b0;
    end

    n = 0;
    while (!memory_response_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: response_ready stayed 0, expected 1 within 50 cycles");
    end

    if (!abort) begin
      repeat (hold) @(negedge clock);
      memory_request_ready = 1'b0;
    end

    n = 0;
    while (memory_response_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL release_timeout: response_ready stayed 1, expected 0 within 50 cycles");
    end
  endtask

  task automatic reset_mid_access(input logic [15:0] data, input logic [15:0] addr);
    @(negedge clock);
    memory_request       = {1'b1, data, addr};
    memory_request_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, memory_response_ready}, 32'd0);
    check("rst_resp", {16'd0, memory_response}, 32'd0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    memory_request_ready = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // stimulus
  initial begin
    logic [15:0] a, d;
    bit w, ab, sc;
    int h, ad;

    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    reset                = 1'b0;
    memory_request       = '0;
    memory_request_ready = 1'b0;
    #3;
    check("reset_resp", {16'd0, memory_response}, 32'd0);
    check("reset_ready", {31'd0, memory_response_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run_txn(1'b0, 16'h0000, 16'd13, 1, 1'b0, 0, 1'b0, '0);
    run_txn(1'b1, 16'd55, 16'd13, 0, 1'b0, 0, 1'b0, '0);
    run_txn(1'b0, 16'h0000, 16'd13, 2, 1'b0, 0, 1'b0, '0);
    run_txn(1'b1, 16'hBEEF, 16'h0105, 0, 1'b0, 0, 1'b0, '0);
    run_txn(1'b0, 16'h0000, 16'h0005, 0, 1'b0, 0, 1'b0, '0);
    run_txn(1'b0, 16'h0000, 16'd2, 1, 1'b0, 0, 1'b1, {1'b1, 16'h1234, 16'd2});
    run_txn(1'b0, 16'h0000, 16'd2, 0, 1'b0, 0, 1'b0, '0);
    run_txn(1'b1, 16'h00AA, 16'd7, 0, 1'b1, 1, 1'b0, '0);
    run_txn(1'b0, 16'h0000, 16'd7, 0, 1'b0, 0, 1'b0, '0);
    reset_mid_access(16'h7777, 16'd9);
    run_txn(1'b0, 16'h0000, 16'd9, 0, 1'b0, 0, 1'b0, '0);
    run_txn(1'b0, 16'h0000, 16'd13, 0, 1'b0, 0, 1'b0, '0);

    for (int t = 0; t < 80; t++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 15));
      d  = 16'($urandom);
      h  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 5) == 0);
      ad = $urandom_range(0, LATENCY - 1);
      sc = ($urandom_range(0, 3) == 0);
      run_txn(w, d, a, h, ab, ad, sc, 33'({$urandom, $urandom}));
    end

    repeat (4) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Backing-store stage directly downstream of the cache.
- Consumes the cache's 33-bit memory_request / memory_request_ready and returns 16-bit words on memory_response / memory_response_ready.
- Holds a word-addressed storage array and models fixed access latency.
- Services one transaction at a time using a four-phase handshake.

Parameters:
- ADDR_BITS, 8, number of low address bits used to index storage (DEPTH = 2^ADDR_BITS 16-bit words).
- LATENCY, 4, cycles from request capture to response assertion; legal range 1..15.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- memory_request  input  33  bit 32 = write (1) / read (0); bits 31:16 = write data; bits 15:0 = word address.
- memory_request_ready  input  1  request valid level; cache holds it high until it has seen the response.
- memory_response  output  16  read data, or echo of the written data for writes.
- memory_response_ready  output  1  response valid level.
- busy  output  1  high from request capture until handshake completion.

Behaviour:
- Reset (reset low, asynchronous, no clock needed):
  - state = IDLE; memory_response = 0; memory_response_ready = 0; busy = 0; latency counter = 0.
  - Every storage word is cleared to 0.
  - The block resumes on the first rising edge after reset returns high.
- State IDLE:
  - On a rising edge with memory_request_ready = 1, latch the entire memory_request into an internal register, set busy = 1, load counter = LATENCY - 1, go to ACCESS.
  - With memory_request_ready = 0, remain in IDLE.
- State ACCESS:
  - Counter decrements every cycle. Changes on memory_request during ACCESS are ignored; only the latched copy is used.
  - When counter = 0:
    - Write: store[addr[ADDR_BITS-1:0]] <= data; memory_response <= data.
    - Read: memory_response <= store[addr[ADDR_BITS-1:0]].
    - Set memory_response_ready = 1; go to RESPOND.
- Latency: memory_response_ready rises exactly LATENCY rising edges after the capture edge. With LATENCY = 1, it is high on the edge after capture.
- State RESPOND:
  - memory_response and memory_response_ready hold steady while memory_request_ready = 1.
  - On an edge with memory_request_ready = 0: memory_response_ready = 0, busy = 0, memory_response retains its last value, go to IDLE.
- A new request is only accepted from IDLE, so at least one idle cycle separates back-to-back transactions.
- Address wrap: address bits above ADDR_BITS-1 are ignored. With the default, address 0x0100 aliases 0x0000.
- memory_request_ready dropped during ACCESS (cache abort): the access still completes and a write still commits. memory_response_ready pulses high for one cycle in RESPOND, then the block returns to IDLE.
- Reset mid-ACCESS: any pending write is discarded (not committed) and the block returns to IDLE.
- Read of a never-written address returns 0.
- Write followed by a read of the same address returns the written data.

Test Plan:
- Reset, then read address 13 with LATENCY = 4 -> memory_response_ready rises 4 edges after capture; memory_response = 0x0000; busy high throughout.
- Write 55 to address 13, drop memory_request_ready after the response, then read 13 -> write response = 55; read response = 55; memory_response_ready falls one edge after memory_request_ready drops.
- Write 0xBEEF to address 0x0105, then read 0x0005 -> 0xBEEF (alias wrap with ADDR_BITS = 8).
- While in ACCESS for a read of address 2, change memory_request to a write of 0x1234 at address 2 -> response returns the original contents of address 2; address 2 is unchanged.
- Drop memory_request_ready mid-ACCESS of a write of 0x00AA to address 7 -> memory_response_ready is a 1-cycle pulse; block returns to IDLE; a later read of address 7 = 0x00AA.
- Assert reset low mid-ACCESS of a write of 0x7777 to address 9 -> outputs go to 0 immediately; after release, a read of address 9 = 0x0000.
